input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Front end for the board-level ALU stage: conditions the raw switch bank and push-buttons.
//  Switches pass through a 2-flop synchronizer. Each button is synchronized, debounced and
//  turned into a single-cycle load pulse (o_btn_pulse[k]).
//  Pulses drive the ALU's operand-A / operand-B / opcode load enables directly.
// PARAMETERS
//  BUS_SIZE         8          switch bus width (matches ALU data bus)
//  N_BUTTONS        3          number of button channels
//  DEBOUNCE_CYCLES  1000000    consecutive stable cycles required (10 ms @ 100 MHz); must be >= 2
//  CNT_WIDTH        localparam $clog2(DEBOUNCE_CYCLES+1); not overridable
// PORTS
//  i_clock       in   1          system clock; all state on rising edge
//  i_reset       in   1          synchronous, active-high reset
//  i_switches    in   BUS_SIZE   raw asynchronous switch inputs
//  i_buttons     in   N_BUTTONS  raw asynchronous buttons; bit0=A load, bit1=B load, bit2=opcode load
//  o_switches    out  BUS_SIZE   synchronized switch value
//  o_btn_level   out  N_BUTTONS  debounced button level
//  o_btn_pulse   out  N_BUTTONS  one-cycle pulse per confirmed press
// BEHAVIOUR
//  - Reset (i_reset high at a clock edge):
//    - all sync flops, counters and outputs go to 0; every channel FSM goes to IDLE.
//    - Applies mid-debounce or mid-hold, and takes precedence over everything else.
//  - Switch path: two flops, no debounce. o_switches = i_switches delayed by exactly 2 cycles.
//  - Button channel: 2-flop sync -> s; 4-state FSM with counter cnt (CNT_WIDTH bits).
//    - IDLE:      s==1 -> PRESS_WAIT, cnt<=1.
//    - PRESS_WAIT:
//      - s==0 -> IDLE, cnt<=0 (bounce rejected).
//      - s==1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; o_btn_pulse<=1 for one cycle; o_btn_level<=1.
//      - otherwise cnt<=cnt+1.
//    - HELD:      s==0 -> RELEASE_WAIT, cnt<=1; s==1 stays, no further pulses (no auto-repeat).
//    - RELEASE_WAIT:
//      - s==1 -> HELD, cnt<=0.
//      - s==0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; o_btn_level<=0.
//      - otherwise cnt<=cnt+1.
//  - Latency: raw press first sampled at edge k -> o_btn_pulse high in cycle k+2+DEBOUNCE_CYCLES.
//    Release has the same latency to o_btn_level falling.
//  - o_btn_pulse is registered, high exactly one cycle per press, never two cycles in a row.
//  - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
//  - Channels are fully independent; simultaneous presses give coincident pulses.
//    No priority or arbitration; the downstream loads all asserted registers in the same cycle.
//  - A button held through reset release re-debounces from IDLE and produces exactly one pulse.
//  - Bounce shorter than DEBOUNCE_CYCLES on press or release produces no pulse and no level change.
// STRUCTURE
//  - Shared package (input_conditioner_pkg):
//    - state localparams IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3;
//    - default DEBOUNCE_CYCLES.
//  - Sub-module debounce_channel (1 button: sync, FSM, counter, level, pulse).
//    Top instantiates it N_BUTTONS times via generate and adds the switch synchronizer.
// TESTING (DEBOUNCE_CYCLES=4 in bench)
//  1 Clean press: i_buttons=3'b001 held 20 cycles from edge 0.
//    -> o_btn_pulse=3'b001 in cycle 6 only; o_btn_level[0]=1 from cycle 6.
//  2 Bounce: bit1 toggles 1,0,1,0 on consecutive cycles, then stays 0.
//    -> no pulse; o_btn_level stays 0.
//  3 Release debounce: after test 1, drop bit0 with one 1-cycle glitch back high.
//    -> o_btn_level[0] falls 6 cycles after the last raw high; no extra pulse.
//  4 Simultaneous: i_buttons 000->111 at same edge.
//    -> o_btn_pulse=3'b111 in one cycle.
//    With i_switches=8'hA5, o_switches=8'hA5 two cycles after applied.
//  5 Reset mid-debounce: press bit2, assert i_reset for 1 cycle at cycle 3, keep button high.
//    -> all outputs 0 during reset; a single pulse 6 cycles after reset deasserts.
//  6 Long hold: bit0 held 100 cycles -> exactly one pulse; level stays 1 throughout.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner.
//   - Default debounce length (10 ms at 100 MHz).
//   - Encodings for the per-button debounce FSM.
package input_conditioner_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    typedef logic [1:0] db_state_t;

    localparam db_state_t IDLE         = 2'd0;
    localparam db_state_t PRESS_WAIT   = 2'd1;
    localparam db_state_t HELD         = 2'd2;
    localparam db_state_t RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/input_conditioner_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM with stability
// counter, registered debounced level and a one-cycle pulse per confirmed press.
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   button  in   raw asynchronous button
//   level   out  debounced level
//   pulse   out  one-cycle pulse on each confirmed press
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | raw high seen, counting stable-high samples
// HELD         | press confirmed, waiting for release
// RELEASE_WAIT | raw low seen while held, counting stable-low samples
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic pulse
);

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    logic                 sync_meta;
    logic                 sync;
    db_state_t            state;
    db_state_t            state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 level_next;
    logic                 pulse_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= button;
            sync      <= sync_meta;
        end
    end

    // State register; level and pulse are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
            pulse <= pulse_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sync) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_next = HELD;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!sync) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_next = HELD;
                    cnt_next   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    always_comb begin
        pulse_next = 1'b0;
        level_next = level;
        if (state == PRESS_WAIT && sync && cnt == CNT_LAST) begin
            pulse_next = 1'b1;
            level_next = 1'b1;
        end else if (state == RELEASE_WAIT && !sync && cnt == CNT_LAST) begin
            level_next = 1'b0;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board-level input conditioner in front of the ALU stage.
// Switches are synchronized (2 flops, no debounce). Each button runs through
// its own debounce_channel producing a debounced level and a load pulse
// (bit0 = operand A, bit1 = operand B, bit2 = opcode).
// Ports:
//   i_clock      in   system clock
//   i_reset      in   synchronous active-high reset
//   i_switches   in   raw switch bank
//   i_buttons    in   raw buttons
//   o_switches   out  synchronized switches (2-cycle delay)
//   o_btn_level  out  debounced button levels
//   o_btn_pulse  out  one-cycle pulse per confirmed press
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int BUS_SIZE        = 8,
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [BUS_SIZE-1:0]  i_switches,
    input  logic [N_BUTTONS-1:0] i_buttons,
    output logic [BUS_SIZE-1:0]  o_switches,
    output logic [N_BUTTONS-1:0] o_btn_level,
    output logic [N_BUTTONS-1:0] o_btn_pulse
);

    logic [BUS_SIZE-1:0] switches_meta;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            switches_meta <= '0;
            o_switches    <= '0;
        end else begin
            switches_meta <= i_switches;
            o_switches    <= switches_meta;
        end
    end

    for (genvar k = 0; k < N_BUTTONS; k++) begin : g_btn
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_channel (
            .clock (i_clock),
            .reset (i_reset),
            .button(i_buttons[k]),
            .level (o_btn_level[k]),
            .pulse (o_btn_pulse[k])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int DC = 4;
    localparam int NB = 3;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [BW-1:0] sw  = '0;
    logic [NB-1:0] btn = '0;
    logic [BW-1:0] o_sw;
    logic [NB-1:0] o_level;
    logic [NB-1:0] o_pulse;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: each channel flips its debounced level once the
    // synchronized input has disagreed with it on DC consecutive samples.
    logic [NB-1:0] m_q1, m_q2, m_level, m_pulse;
    logic [BW-1:0] m_sw1, m_sw2;
    int            m_run [NB];

    always #5 clk = ~clk;

    input_conditioner #(
        .BUS_SIZE       (BW),
        .N_BUTTONS      (NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_switches (sw),
        .i_buttons  (btn),
        .o_switches (o_sw),
        .o_btn_level(o_level),
        .o_btn_pulse(o_pulse)
    );

    // Advance one clock edge, update the model with the inputs seen at that
    // edge, then move 1 time unit past the edge for sampling and driving.
    task automatic tick();
        logic s;
        @(posedge clk);
        if (rst) begin
            m_q1 = '0; m_q2 = '0; m_level = '0; m_pulse = '0;
            m_sw1 = '0; m_sw2 = '0;
            for (int k = 0; k < NB; k++) m_run[k] = 0;
        end else begin
            m_pulse = '0;
            for (int k = 0; k < NB; k++) begin
                s = m_q2[k];
                if (s != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DC) begin
                        m_level[k] = s;
                        m_pulse[k] = s;
                        m_run[k]   = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_q2  = m_q1;
            m_q1  = btn;
            m_sw2 = m_sw1;
            m_sw1 = sw;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = '0;
        sw  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            btn = NB'($urandom);
            sw  = BW'($urandom);
            tick();
            n_cmp++;
            if ({o_sw, o_level, o_pulse} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got sw=%h level=%b pulse=%b, want all zero", o_sw, o_level, o_pulse);
            end
        end
        rst = 1'b0;
        btn = '0;
        sw  = '0;
    endtask

    // Press sampled at edge index 0; pulse appears after edge index DC+1 = 5.
    task automatic test_clean_press();
        do_reset();
        btn = 3'b001;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (o_pulse !== ((i == 5) ? 3'b001 : 3'b000)) begin
                n_err++;
                $display("FAIL clean_press_pulse[%0d]: got %b want %b", i, o_pulse, (i == 5) ? 3'b001 : 3'b000);
            end
            n_cmp++;
            if (o_level !== ((i >= 5) ? 3'b001 : 3'b000)) begin
                n_err++;
                $display("FAIL clean_press_level[%0d]: got %b want %b", i, o_level, (i >= 5) ? 3'b001 : 3'b000);
            end
            n_cmp++;
            if (o_pulse !== m_pulse || o_level !== m_level) begin
                n_err++;
                $display("FAIL clean_press_model[%0d]: got p=%b l=%b want p=%b l=%b", i, o_pulse, o_level, m_pulse, m_level);
            end
        end
    endtask

    // Continues from a held bit0: low, one-cycle glitch high, then low.
    // Last raw high at index 1, so level falls after index 7.
    task automatic test_release_debounce();
        for (int i = 0; i < 14; i++) begin
            btn = (i == 1) ? 3'b001 : 3'b000;
            tick();
            n_cmp++;
            if (o_level[0] !== ((i < 7) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL release_level[%0d]: got %b want %b", i, o_level[0], (i < 7) ? 1'b1 : 1'b0);
            end
            n_cmp++;
            if (o_pulse !== 3'b000 || o_pulse !== m_pulse || o_level !== m_level) begin
                n_err++;
                $display("FAIL release_model[%0d]: got p=%b l=%b want p=%b l=%b", i, o_pulse, o_level, m_pulse, m_level);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            btn = (i < 4 && (i % 2) == 0) ? 3'b010 : 3'b000;
            tick();
            n_cmp++;
            if (o_pulse !== 3'b000 || o_level !== 3'b000) begin
                n_err++;
                $display("FAIL bounce[%0d]: got p=%b l=%b want p=000 l=000", i, o_pulse, o_level);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        btn = 3'b111;
        sw  = 8'hA5;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (o_pulse !== ((i == 5) ? 3'b111 : 3'b000)) begin
                n_err++;
                $display("FAIL simul_pulse[%0d]: got %b want %b", i, o_pulse, (i == 5) ? 3'b111 : 3'b000);
            end
            if (i >= 1) begin
                n_cmp++;
                if (o_sw !== 8'hA5) begin
                    n_err++;
                    $display("FAIL simul_switches[%0d]: got %h want a5", i, o_sw);
                end
            end else begin
                n_cmp++;
                if (o_sw !== 8'h00) begin
                    n_err++;
                    $display("FAIL simul_switches_early[%0d]: got %h want 00", i, o_sw);
                end
            end
        end
    endtask

    // Reset at edge index 3; button stays high, first post-reset sample at
    // index 4, so the single pulse lands at index 9.
    task automatic test_reset_mid_debounce();
        int npulse;
        do_reset();
        npulse = 0;
        btn = 3'b100;
        for (int i = 0; i < 16; i++) begin
            rst = (i == 3);
            tick();
            if (i == 3) begin
                n_cmp++;
                if ({o_sw, o_level, o_pulse} !== '0) begin
                    n_err++;
                    $display("FAIL midreset_outputs: got sw=%h l=%b p=%b want zeros", o_sw, o_level, o_pulse);
                end
            end
            n_cmp++;
            if (o_pulse !== ((i == 9) ? 3'b100 : 3'b000)) begin
                n_err++;
                $display("FAIL midreset_pulse[%0d]: got %b want %b", i, o_pulse, (i == 9) ? 3'b100 : 3'b000);
            end
            if (o_pulse[2]) npulse++;
        end
        rst = 1'b0;
        n_cmp++;
        if (npulse != 1) begin
            n_err++;
            $display("FAIL midreset_pulse_count: got %0d want 1", npulse);
        end
    endtask

    task automatic test_long_hold();
        int npulse;
        bit seen;
        do_reset();
        npulse = 0;
        seen   = 0;
        btn    = 3'b001;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_pulse[0]) npulse++;
            if (seen) begin
                n_cmp++;
                if (o_level[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL long_hold_level[%0d]: got %b want 1", i, o_level[0]);
                end
            end
            if (o_level[0] === 1'b1) seen = 1;
        end
        n_cmp++;
        if (npulse != 1) begin
            n_err++;
            $display("FAIL long_hold_pulses: got %0d want 1", npulse);
        end
    endtask

    task automatic test_random();
        int hold [NB];
        logic [NB-1:0] prev_pulse;
        do_reset();
        prev_pulse = '0;
        for (int k = 0; k < NB; k++) hold[k] = 0;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NB; k++) begin
                if (hold[k] == 0) begin
                    btn[k]  = ~btn[k];
                    hold[k] = $urandom_range(1, 9);
                end
                hold[k]--;
            end
            sw  = BW'($urandom);
            rst = ($urandom_range(0, 79) == 0);
            tick();
            n_cmp++;
            if (o_pulse !== m_pulse || o_level !== m_level || o_sw !== m_sw2) begin
                n_err++;
                $display("FAIL random[%0d]: got p=%b l=%b sw=%h want p=%b l=%b sw=%h",
                         i, o_pulse, o_level, o_sw, m_pulse, m_level, m_sw2);
            end
            n_cmp++;
            if ((o_pulse & prev_pulse) !== '0) begin
                n_err++;
                $display("FAIL random_double_pulse[%0d]: got %b after %b want no repeat", i, o_pulse, prev_pulse);
            end
            prev_pulse = o_pulse;
        end
        rst = 1'b0;
    endtask

    initial begin
        m_q1 = '0; m_q2 = '0; m_level = '0; m_pulse = '0;
        m_sw1 = '0; m_sw2 = '0;
        for (int k = 0; k < NB; k++) m_run[k] = 0;
        test_reset();
        test_clean_press();
        test_release_debounce();
        test_bounce();
        test_simultaneous();
        test_reset_mid_debounce();
        test_long_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
